// File: rtl/vram_pkg.sv
// Shared types and widths for the video RAM arbiter.
//   VRAM_AW    - video RAM address width (8 KB)
//   VRAM_DW    - video RAM data width
//   vram_tag_t - owner tag carried alongside each RAM access in flight
package vram_pkg;

  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } vram_tag_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_pix - clock, rising edge
//   reset   - asynchronous active-high reset
//   clr     - synchronous clear, wins over inc
//   inc     - increment request; ignored once the count is all-ones
//   count   - current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_pix,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count != '1)) begin
      count_d = count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the video fetcher and the Z80.
// One RAM access is granted per clk_pix; its result returns two edges later.
//   clk_pix, reset                   - clock and asynchronous active-high reset
//   vid_req/vid_addr                 - video fetch strobe and address
//   vid_data/vid_valid               - fetched byte, in request order
//   cpu_req/cpu_we/cpu_addr/cpu_wdata - CPU access, held until cpu_ack
//   cpu_rdata/cpu_ack/cpu_wait_n     - CPU completion and Z80 WAIT
//   ram_addr/ram_we/ram_wdata/ram_rdata - registered VRAM port
//   stat_clr/contention_cnt          - contention statistic
//   vid_overrun                      - sticky dropped-video flag
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned CPU_MAX_WAIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_addr,
  output logic [VRAM_DW-1:0] vid_data,
  output logic               vid_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  output logic [VRAM_DW-1:0] cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_wait_n,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic               ram_we,
  output logic [VRAM_DW-1:0] ram_wdata,
  input  logic [VRAM_DW-1:0] ram_rdata,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   contention_cnt,
  output logic               vid_overrun
);

  // Wide enough to hold CPU_MAX_WAIT, and never zero bits wide.
  localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 2);

  logic               cpu_busy_q, cpu_busy_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               buf_valid_q, buf_valid_d;
  logic [VRAM_AW-1:0] buf_addr_q, buf_addr_d;
  vram_tag_t          tag0_q, tag0_d, tag1_q;
  logic               overrun_d;
  logic [VRAM_AW-1:0] ram_addr_d;
  logic               ram_we_d;
  logic [VRAM_DW-1:0] ram_wdata_d;
  logic               cpu_elig, cpu_force;
  logic               grant_cpu, grant_buf, grant_live;

  always_comb begin
    cpu_elig   = cpu_req && !cpu_busy_q;
    cpu_force  = cpu_elig && (wait_cnt_q >= WAIT_W'(CPU_MAX_WAIT));
    grant_cpu  = 1'b0;
    grant_buf  = 1'b0;
    grant_live = 1'b0;
    if (cpu_force) begin
      grant_cpu = 1'b1;
    end else if (buf_valid_q) begin
      grant_buf = 1'b1;
    end else if (vid_req) begin
      grant_live = 1'b1;
    end else if (cpu_elig) begin
      grant_cpu = 1'b1;
    end

    // Idle: address and write data hold, no write strobe.
    ram_addr_d  = ram_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata;
    tag0_d      = TAG_NONE;
    if (grant_cpu) begin
      ram_addr_d = cpu_addr;
      ram_we_d   = cpu_we;
      if (cpu_we) begin
        ram_wdata_d = cpu_wdata;
      end
      tag0_d = TAG_CPU;
    end else if (grant_buf) begin
      ram_addr_d = buf_addr_q;
      tag0_d     = TAG_VID;
    end else if (grant_live) begin
      ram_addr_d = vid_addr;
      tag0_d     = TAG_VID;
    end

    // A live request that lost goes to the defer slot if it is free or being drained now.
    buf_valid_d = buf_valid_q && !grant_buf;
    buf_addr_d  = buf_addr_q;
    overrun_d   = vid_overrun;
    if (vid_req && !grant_live) begin
      if (!buf_valid_d) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = vid_addr;
      end else begin
        overrun_d = 1'b1;
      end
    end

    cpu_busy_d = cpu_busy_q;
    if (tag1_q == TAG_CPU) begin
      cpu_busy_d = 1'b0;
    end
    if (grant_cpu) begin
      cpu_busy_d = 1'b1;
    end

    wait_cnt_d = wait_cnt_q;
    if (grant_cpu) begin
      wait_cnt_d = '0;
    end else if (cpu_elig) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      vid_valid   <= 1'b0;
      vid_data    <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      cpu_busy_q  <= 1'b0;
      wait_cnt_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      vid_overrun <= 1'b0;
    end else begin
      ram_addr    <= ram_addr_d;
      ram_we      <= ram_we_d;
      ram_wdata   <= ram_wdata_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
      vid_valid   <= (tag1_q == TAG_VID);
      cpu_ack     <= (tag1_q == TAG_CPU);
      if (tag1_q == TAG_VID) begin
        vid_data <= ram_rdata;
      end
      if (tag1_q == TAG_CPU) begin
        cpu_rdata <= ram_rdata;
      end
      cpu_busy_q  <= cpu_busy_d;
      wait_cnt_q  <= wait_cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      vid_overrun <= overrun_d;
    end
  end

  assign cpu_wait_n = !(cpu_req && !cpu_ack);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_contention (
    .clk_pix(clk_pix),
    .reset  (reset),
    .clr    (stat_clr),
    .inc    (cpu_elig && !grant_cpu),
    .count  (contention_cnt)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned MAXW  = 4;
  localparam int unsigned CNT_W = 16;

  logic               clk_pix = 1'b0;
  logic               reset;
  logic               vid_req;
  logic [VRAM_AW-1:0] vid_addr;
  logic [VRAM_DW-1:0] vid_data;
  logic               vid_valid;
  logic               cpu_req;
  logic               cpu_we;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [VRAM_DW-1:0] cpu_wdata;
  logic [VRAM_DW-1:0] cpu_rdata;
  logic               cpu_ack;
  logic               cpu_wait_n;
  logic [VRAM_AW-1:0] ram_addr;
  logic               ram_we;
  logic [VRAM_DW-1:0] ram_wdata;
  logic [VRAM_DW-1:0] ram_rdata;
  logic               stat_clr;
  logic [CNT_W-1:0]   contention_cnt;
  logic               vid_overrun;

  vram_arbiter #(
    .CPU_MAX_WAIT(MAXW),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_pix       (clk_pix),
    .reset         (reset),
    .vid_req       (vid_req),
    .vid_addr      (vid_addr),
    .vid_data      (vid_data),
    .vid_valid     (vid_valid),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ack       (cpu_ack),
    .cpu_wait_n    (cpu_wait_n),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .stat_clr      (stat_clr),
    .contention_cnt(contention_cnt),
    .vid_overrun   (vid_overrun)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i) ^ 8'h47;
  endfunction

  // VRAM macro: 1-cycle registered read, bulk preload at start.
  logic       preload;
  logic [7:0] mem [0:8191];
  always @(posedge clk_pix) begin
    if (preload) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_byte(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int vv_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns each edge, and the result each owner is due two edges later.
  logic [7:0]  shadow [0:8191];
  logic [12:0] vq [$];          // deferred video addresses, capacity one
  bit          cpu_inflight;
  int          lost;
  int          cont;
  bit          ovr;
  int          cyc;
  int          due_kind [4];    // 0 none, 1 video, 2 cpu read, 3 cpu write
  logic [7:0]  due_data [4];
  bit          e_vv, e_ack, e_ack_rd, e_ram_we;
  logic [7:0]  e_vd, e_rd, e_ram_wd;
  logic [12:0] e_ram_addr;

  task automatic model_reset();
    vq.delete();
    cpu_inflight = 0; lost = 0; cont = 0; ovr = 0; cyc = 0;
    for (int i = 0; i < 4; i++) due_kind[i] = 0;
    e_vv = 0; e_ack = 0; e_ack_rd = 0; e_ram_we = 0;
    e_vd = 0; e_rd = 0; e_ram_wd = 0; e_ram_addr = 0;
  endtask

  task automatic model_step();
    int          slot = cyc % 4;
    int          nxt  = (cyc + 2) % 4;
    bit          elig = cpu_req && !cpu_inflight;
    int          who  = 0;
    bit          live = 0;
    logic [12:0] ga   = '0;
    if (elig && lost >= int'(MAXW)) who = 2;
    else if (vq.size() > 0) begin who = 1; ga = vq.pop_front(); end
    else if (vid_req) begin who = 1; live = 1; ga = vid_addr; end
    else if (elig) who = 2;
    if (vid_req && !live) begin
      if (vq.size() == 0) vq.push_back(vid_addr);
      else ovr = 1;
    end
    if (stat_clr) cont = 0;
    else if (elig && who != 2 && cont < (1 << CNT_W) - 1) cont++;
    if (who == 2) lost = 0;
    else if (elig) lost++;
    e_vv = 0; e_ack = 0;
    if (due_kind[slot] == 1) begin
      e_vv = 1; e_vd = due_data[slot];
    end else if (due_kind[slot] >= 2) begin
      e_ack = 1; e_ack_rd = (due_kind[slot] == 2); e_rd = due_data[slot];
      cpu_inflight = 0;
    end
    due_kind[slot] = 0;
    e_ram_we = 0;
    if (who == 1) begin
      e_ram_addr = ga; due_kind[nxt] = 1; due_data[nxt] = shadow[ga];
    end else if (who == 2) begin
      cpu_inflight = 1; e_ram_addr = cpu_addr;
      if (cpu_we) begin
        shadow[cpu_addr] = cpu_wdata; e_ram_we = 1; e_ram_wd = cpu_wdata; due_kind[nxt] = 3;
      end else begin
        due_kind[nxt] = 2; due_data[nxt] = shadow[cpu_addr];
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    check_eq("vid_valid", 32'(vid_valid), 32'(e_vv));
    if (e_vv) check_eq("vid_data", 32'(vid_data), 32'(e_vd));
    check_eq("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    if (e_ack && e_ack_rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
    check_eq("cpu_wait_n", 32'(cpu_wait_n), 32'(!(cpu_req && !e_ack)));
    check_eq("ram_we", 32'(ram_we), 32'(e_ram_we));
    check_eq("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
    if (e_ram_we) check_eq("ram_wdata", 32'(ram_wdata), 32'(e_ram_wd));
    check_eq("contention_cnt", 32'(contention_cnt), 32'(cont));
    check_eq("vid_overrun", 32'(vid_overrun), 32'(ovr));
  endtask

  // One clock: model the edge, sample 1 ns later, CPU drops its request on ack.
  task automatic tick();
    @(posedge clk_pix);
    model_step();
    #1;
    compare_all();
    if (vid_valid) vv_cnt++;
    if (e_ack) cpu_req = 1'b0;
  endtask

  task automatic idle(input int n);
    vid_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_start(input bit we, input logic [12:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
    #1;
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check_eq("rst_vid_valid", 32'(vid_valid), 32'd0);
    check_eq("rst_vid_data", 32'(vid_data), 32'd0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_contention", 32'(contention_cnt), 32'd0);
    check_eq("rst_overrun", 32'(vid_overrun), 32'd0);
    model_reset();
    @(posedge clk_pix);
    #1;
    reset = 1'b0;
  endtask

  task automatic video_burst(input bit two_cpu);
    vv_cnt = 0;
    cpu_start(1'b0, 13'h1802, 8'h00);
    for (int i = 0; i < 20; i++) begin
      vid_req = 1'b1; vid_addr = 13'(i);
      tick();
      if (i == 4) check_eq("burst_cpu_grant_addr", 32'(ram_addr), 32'h1802);
      if (two_cpu && i == 7) cpu_start(1'b0, 13'h1803, 8'h00);
    end
    idle(10);
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    vid_req = 0; vid_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    stat_clr = 0;
    for (int i = 0; i < 8192; i++) shadow[i] = init_byte(i);
    model_reset();
    repeat (2) @(posedge clk_pix);
    #1;
    preload = 1'b0;
    check_eq("reset_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("reset_contention", 32'(contention_cnt), 32'd0);
    reset = 1'b0;
    idle(2);

    // Lone CPU read.
    cpu_start(1'b0, 13'h1800, 8'h00);
    tick();
    check_eq("t1_wait_n_e0", 32'(cpu_wait_n), 32'd0);
    tick();
    check_eq("t1_wait_n_e1", 32'(cpu_wait_n), 32'd0);
    tick();
    check_eq("t1_ack", 32'(cpu_ack), 32'd1);
    check_eq("t1_rdata", 32'(cpu_rdata), 32'h47);
    idle(3);

    // Simultaneous video and CPU requests.
    vid_req = 1'b1; vid_addr = 13'h0000;
    cpu_start(1'b0, 13'h1801, 8'h00);
    tick();
    vid_req = 1'b0;
    tick();
    tick();
    check_eq("t2_vid_valid", 32'(vid_valid), 32'd1);
    check_eq("t2_vid_data", 32'(vid_data), 32'h47);
    tick();
    check_eq("t2_cpu_ack", 32'(cpu_ack), 32'd1);
    check_eq("t2_cpu_rdata", 32'(cpu_rdata), 32'h46);
    check_eq("t2_contention", 32'(contention_cnt), 32'd1);
    idle(3);

    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("stat_clr", 32'(contention_cnt), 32'd0);

    // Continuous video with one forced CPU access.
    video_burst(1'b0);
    check_eq("t3_vid_count", 32'(vv_cnt), 32'd20);
    check_eq("t3_overrun", 32'(vid_overrun), 32'd0);
    check_eq("t3_contention", 32'(contention_cnt), 32'd4);

    // Two CPU accesses inside the burst: the second forced grant drops a fetch.
    video_burst(1'b1);
    check_eq("t4_vid_count", 32'(vv_cnt), 32'd19);
    check_eq("t4_overrun", 32'(vid_overrun), 32'd1);

    // CPU write then readback.
    cpu_start(1'b1, 13'h1ABC, 8'h5A);
    tick();
    check_eq("t5_we", 32'(ram_we), 32'd1);
    check_eq("t5_addr", 32'(ram_addr), 32'h1ABC);
    check_eq("t5_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    check_eq("t5_we_low", 32'(ram_we), 32'd0);
    tick();
    check_eq("t5_ack", 32'(cpu_ack), 32'd1);
    cpu_start(1'b0, 13'h1ABC, 8'h00);
    tick(); tick(); tick();
    check_eq("t5_readback", 32'(cpu_rdata), 32'h5A);
    idle(2);

    // Reset one cycle after a CPU grant cancels the access.
    cpu_start(1'b0, 13'h1800, 8'h00);
    tick();
    pulse_reset();
    vv_cnt = 0;
    idle(4);
    check_eq("t6_no_ack", 32'(cpu_ack), 32'd0);
    cpu_start(1'b0, 13'h1801, 8'h00);
    tick(); tick(); tick();
    check_eq("t6_ack", 32'(cpu_ack), 32'd1);
    check_eq("t6_rdata", 32'(cpu_rdata), 32'h46);
    idle(2);

    // Randomized traffic at several video loads.
    for (int ph = 0; ph < 3; ph++) begin
      int pct = (ph == 0) ? 30 : (ph == 1) ? 70 : 100;
      for (int i = 0; i < 600; i++) begin
        vid_req  = ($urandom_range(0, 99) < pct);
        vid_addr = 13'($urandom);
        stat_clr = ($urandom_range(0, 99) < 3);
        if (!cpu_req && !cpu_inflight && $urandom_range(0, 99) < 30) begin
          cpu_start(1'($urandom), 13'($urandom), 8'($urandom));
        end
        tick();
      end
      stat_clr = 1'b0;
      idle(8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
